// File: rtl/tx_tone_pkg.sv
// Shared types and defaults for the two-tone DDS sequencer.
package tx_tone_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    SETTLE = 3'd3,
    DWELL  = 3'd4
  } state_e;

  localparam int TBL_AW_DEF     = 3;
  localparam int FW_DEF         = 25;
  localparam int DW_DEF         = 16;
  localparam int FLUSH_CYC_DEF  = 4;
  localparam int SETTLE_CYC_DEF = 13;

  typedef struct packed {
    logic [FW_DEF-1:0] freq0;
    logic [FW_DEF-1:0] freq1;
    logic              sel;
    logic [DW_DEF-1:0] dwell;
  } tone_entry_t;

  localparam tone_entry_t ENTRY_RST = '0;
  localparam int          ENTRY_W   = $bits(tone_entry_t);

endpackage

// File: rtl/tx_tone_table.sv
// Tone entry register file: sync write, combinational read.
module tx_tone_table
  import tx_tone_pkg::*;
#(
  parameter int AW = TBL_AW_DEF,
  parameter int EW = ENTRY_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);

  localparam int DEPTH = 2**AW;

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_tone_sched_ctrl.sv
// Walks the tone table: program DDS, flush, settle, then dwell.
module tx_tone_sched_ctrl
  import tx_tone_pkg::*;
#(
  parameter int TBL_AW     = TBL_AW_DEF,
  parameter int FW         = FW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FLUSH_CYC  = FLUSH_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk_msk_in,
  input  logic              logic_rst_in,
  input  logic              cfg_we,
  input  logic [TBL_AW-1:0] cfg_addr,
  input  logic [FW-1:0]     cfg_freq0,
  input  logic [FW-1:0]     cfg_freq1,
  input  logic              cfg_sel,
  input  logic [DW-1:0]     cfg_dwell,
  input  logic [TBL_AW:0]   num_entries,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [FW-1:0]     dds_freq0,
  output logic [FW-1:0]     dds_freq1,
  output logic              dds_sel,
  output logic              dds_sclr,
  output logic              tone_valid,
  output logic [TBL_AW-1:0] tone_idx,
  output logic              busy,
  output logic              done,
  output logic [63:0]       debug_signal
);

  localparam int EW = 2*FW + 1 + DW;
  localparam int CW = 8;

  localparam logic [TBL_AW:0]   N_MAX   = (TBL_AW+1)'(2**TBL_AW);
  localparam logic [TBL_AW:0]   N_ONE   = (TBL_AW+1)'(1);
  localparam logic [TBL_AW-1:0] IDX_ONE = TBL_AW'(1);
  localparam logic [DW-1:0]     DW_ONE  = DW'(1);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);
  localparam logic [CW-1:0]     FL_LAST = CW'(FLUSH_CYC-1);
  localparam logic [CW-1:0]     ST_LAST = CW'(SETTLE_CYC-1);

  state_e            state_q;
  logic [FW-1:0]     freq0_q, freq1_q;
  logic              sel_q, sclr_q, valid_q;
  logic              busy_q, done_q;
  logic [TBL_AW-1:0] idx_q;
  logic [TBL_AW:0]   n_q;
  logic [DW-1:0]     dwell_q;
  logic [CW-1:0]     cnt_q;

  logic [EW-1:0]     rd;
  logic [FW-1:0]     rd_freq0, rd_freq1;
  logic              rd_sel;
  logic [DW-1:0]     rd_dwell;
  logic              last;

  tx_tone_table #(
    .AW (TBL_AW),
    .EW (EW)
  ) u_table (
    .clk_i   (clk_msk_in),
    .rst_i   (logic_rst_in),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i ({cfg_freq0, cfg_freq1, cfg_sel, cfg_dwell}),
    .raddr_i (idx_q),
    .rdata_o (rd)
  );

  assign rd_freq0 = rd[EW-1 -: FW];
  assign rd_freq1 = rd[DW+1 +: FW];
  assign rd_sel   = rd[DW];
  assign rd_dwell = rd[DW-1:0];
  assign last     = (({1'b0, idx_q} + N_ONE) == n_q);

  always_ff @(posedge clk_msk_in) begin
    if (logic_rst_in) begin
      state_q <= IDLE;
      freq0_q <= '0;
      freq1_q <= '0;
      sel_q   <= 1'b0;
      sclr_q  <= 1'b1;
      valid_q <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop && state_q != IDLE) begin
        state_q <= IDLE;
        sclr_q  <= 1'b1;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !stop) begin
              if (num_entries == '0) begin
                done_q <= 1'b1;
              end else begin
                n_q     <= (num_entries > N_MAX) ? N_MAX : num_entries;
                idx_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= LOAD;
              end
            end
          end
          LOAD: begin
            freq0_q <= rd_freq0;
            freq1_q <= rd_freq1;
            sel_q   <= rd_sel;
            dwell_q <= (rd_dwell == '0) ? DW_ONE : rd_dwell;
            sclr_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= FLUSH;
          end
          FLUSH: begin
            if (cnt_q == FL_LAST) begin
              cnt_q   <= '0;
              sclr_q  <= 1'b0;
              state_q <= SETTLE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          SETTLE: begin
            if (cnt_q == ST_LAST) begin
              valid_q <= 1'b1;
              state_q <= DWELL;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          DWELL: begin
            if (dwell_q == DW_ONE) begin
              valid_q <= 1'b0;
              if (!last) begin
                idx_q   <= idx_q + IDX_ONE;
                state_q <= LOAD;
              end else if (loop_en) begin
                idx_q   <= '0;
                state_q <= LOAD;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                sclr_q  <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              dwell_q <= dwell_q - DW_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dds_freq0  = freq0_q;
  assign dds_freq1  = freq1_q;
  assign dds_sel    = sel_q;
  assign dds_sclr   = sclr_q;
  assign tone_valid = valid_q;
  assign tone_idx   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // flags = {busy, done, tone_valid, dds_sclr, dds_sel}
  assign debug_signal = 64'({state_q, idx_q, dwell_q,
                             busy_q, done_q, valid_q, sclr_q, sel_q});

endmodule

// File: doc/tx_tone_sched_ctrl.md
Name: tx_tone_sched_ctrl

Overview:
- Sequencer for the two-tone DDS DAC test datapath.
- Holds a small table of tone entries. Each entry has freq0 word, freq1 word, second-tone select, and dwell length.
- On start it walks the table. For each entry it programs the DDS frequency words, pulses DDS clear, waits for the DDS/merge pipeline to settle, then asserts tone_valid for the dwell time.
- Sits between the MIF/config registers and the dual-DDS tone generator. It replaces the static frequency words and free-running enable.

Parameters:
- TBL_AW, 3, table address width; depth = 2**TBL_AW = 8 entries.
- FW, 25, DDS frequency word width.
- DW, 16, dwell counter width.
- FLUSH_CYC, 4, cycles dds_sclr is held high per retune.
- SETTLE_CYC, 13, cycles from sclr release to valid output (DDS + amplitude + merge + rounding pipeline).

Ports:
- clk_msk_in  in  1  50 MHz clock.
- logic_rst_in  in  1  synchronous active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  TBL_AW  table write address.
- cfg_freq0  in  FW  tone-0 frequency word.
- cfg_freq1  in  FW  tone-1 frequency word.
- cfg_sel  in  1  enable tone 1 for this entry.
- cfg_dwell  in  DW  dwell cycles; 0 is treated as 1.
- num_entries  in  TBL_AW+1  active entries, 0..8; sampled at start.
- loop_en  in  1  restart at entry 0 after the last entry.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- dds_freq0  out  FW  to DDS 0 data input.
- dds_freq1  out  FW  to DDS 1 data input.
- dds_sel  out  1  to the second-tone select input.
- dds_sclr  out  1  DDS synchronous clear.
- tone_valid  out  1  output samples valid for the current entry.
- tone_idx  out  TBL_AW  entry currently playing.
- busy  out  1  high when the FSM is not IDLE.
- done  out  1  one-cycle pulse when a non-looping sequence completes.
- debug_signal  out  64  {state, tone_idx, dwell_cnt, flags}; zero-padded.

Behaviour:
- Clock and reset: one clock, clk_msk_in. Reset logic_rst_in is synchronous and active-high.
- Reset values: state=IDLE; dds_freq0=0, dds_freq1=0, dds_sel=0, dds_sclr=1 (DDS held clear), tone_valid=0, tone_idx=0, busy=0, done=0. Table contents are also cleared to 0.
- Table writes:
  - Writes are accepted in any state.
  - An entry is read only in LOAD, so a write to the playing entry takes effect on its next LOAD.
- FSM states: IDLE, LOAD, FLUSH, SETTLE, DWELL.
- IDLE:
  - dds_sclr=1, busy=0.
  - When start=1: if num_entries>8 it is clamped to 8. If num_entries=0, done pulses the next cycle and the FSM stays IDLE. Otherwise idx=0 and the FSM goes to LOAD.
- LOAD (1 cycle): latch the table[idx] fields into dds_freq0, dds_freq1, dds_sel and dwell_cnt. A dwell of 0 is loaded as 1. Go to FLUSH.
- FLUSH (FLUSH_CYC cycles): dds_sclr=1. Go to SETTLE.
- SETTLE (SETTLE_CYC cycles): dds_sclr=0, tone_valid=0. Go to DWELL.
- DWELL:
  - tone_valid=1; dwell_cnt decrements each cycle.
  - At count 1, the next state is chosen:
    - idx<num_entries-1: idx+1, go to LOAD.
    - Last entry with loop_en=1: idx=0, go to LOAD.
    - Last entry with loop_en=0: pulse done, go to IDLE.
- Timing from start: start sampled at edge k gives LOAD in cycle k+1. First tone_valid is at cycle k+2+FLUSH_CYC+SETTLE_CYC, i.e. k+19 with defaults. tone_valid is high for exactly dwell cycles, then low for at least 1+FLUSH_CYC+SETTLE_CYC cycles between entries.
- Stop:
  - stop=1 in any non-IDLE state gives IDLE on the next edge.
  - tone_valid drops and dds_sclr rises in that same cycle; done is not pulsed.
  - stop has priority over start and over DWELL completion when they coincide.
- start while busy is ignored.
- loop_en is sampled at each last-entry decision. Clearing it mid-sequence ends the sequence after the current pass.
- tone_idx is updated in LOAD and is stable through FLUSH, SETTLE and DWELL.
- Reset asserted mid-sequence behaves exactly as the reset values above on the next edge.

Decomposition:
- Shared package tx_tone_pkg holds:
  - the state enum/localparams (IDLE=0, LOAD=1, FLUSH=2, SETTLE=3, DWELL=4);
  - the entry record layout {freq0, freq1, sel, dwell}, 67 bits with defaults;
  - the default FLUSH_CYC and SETTLE_CYC constants.
- One sub-module, tx_tone_table: a 2**TBL_AW x 67 register file with a synchronous write port and a combinational read port. The FSM and counters stay in the top.

Test Plan:
- Reset, then idle for 10 cycles: dds_sclr=1, tone_valid=0, busy=0, all frequency outputs 0.
- Load entries 0 and 1:
  - entry 0 = (1342177, 2684354, sel=1, dwell=100); entry 1 = (2684354, 0, sel=0, dwell=50).
  - Set num_entries=2, loop_en=0, start at cycle 0.
  - Required: tone_valid rises at cycle 19 and lasts 100 cycles with tone_idx=0; entry 1 valid for 50 cycles; done pulses once; busy falls.
- Same table with loop_en=1: the sequence repeats entry 0 then entry 1 for 3 passes; clearing loop_en during the third pass gives done after entry 1.
- stop asserted in DWELL of entry 0: the next cycle shows IDLE, tone_valid=0, dds_sclr=1, and no done. A start in the same cycle as stop is ignored.
- num_entries=0 start gives done one cycle later with busy staying 0. An entry with dwell=0 gives exactly 1 valid cycle.
- Write entry 0 with freq0=500000 during its DWELL: current dds_freq0 is unchanged; with loop_en=1, the next pass shows dds_freq0=500000. Reset asserted mid-SETTLE returns all outputs to their reset values on the next edge.
